// File: rtl/dmem_bytelane_if.sv
// Functional and debug access bundle for dmem_bytelane.
// The master drives requests; the slave (memory) returns registered data and status.
interface dmem_bytelane_if;
  logic        Debug_on;
  logic [1:0]  read_write;
  logic [1:0]  size;
  logic        load_unsigned;
  logic [31:0] inAddress;
  logic [31:0] inWriteData;
  logic [31:0] Debug_read_mem;
  logic [31:0] outData;
  logic [31:0] outMemDebug;
  logic        ready;
  logic        fault;

  modport master (
    output Debug_on, read_write, size, load_unsigned,
           inAddress, inWriteData, Debug_read_mem,
    input  outData, outMemDebug, ready, fault
  );

  modport slave (
    input  Debug_on, read_write, size, load_unsigned,
           inAddress, inWriteData, Debug_read_mem,
    output outData, outMemDebug, ready, fault
  );
endinterface

// File: rtl/dmem_bytelane.sv
// Byte-lane data memory with post-reset clear, alignment/range fault
// detection and a side debug read port. All state moves on the falling edge.
module dmem_bytelane #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  dmem_bytelane_if.slave bus
);

  typedef enum logic {CLEAR, IDLE} state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  state_t        state, state_nxt;
  logic [AW-1:0] clr_cnt, clr_cnt_nxt;

  logic [31:0]   mem [DEPTH];

  logic          func_active;
  logic          is_write, is_read;
  logic          in_range, aligned, legal;
  logic          wr_en, rd_en, fault_nxt;
  logic [AW-1:0] word_idx;
  logic [3:0]    lane_en;
  logic [31:0]   lane_data;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_idx;
  logic [31:0]   mem_wdata;
  logic [31:0]   rd_word;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [31:0]   rd_val;
  logic          dbg_in_range;
  logic [31:0]   dbg_word;

  logic [31:0]   out_data_q;
  logic [31:0]   out_dbg_q;
  logic          fault_q;

  // ---------------- FSM ----------------
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    case (state)
      CLEAR: begin
        clr_cnt_nxt = clr_cnt + 1'b1;
        if (clr_cnt == LAST_IDX) state_nxt = IDLE;
      end
      IDLE: ;
      default: state_nxt = CLEAR;
    endcase
  end

  // ---------------- access decode ----------------
  always_comb begin
    func_active = (state == IDLE) && !bus.Debug_on;
    is_write    = (bus.read_write == 2'b01);
    is_read     = (bus.read_write == 2'b10);
    in_range    = (bus.inAddress[31:AW+2] == '0);
    case (bus.size)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = !bus.inAddress[0];
      2'b10:   aligned = (bus.inAddress[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
    legal     = aligned && in_range;
    wr_en     = func_active && is_write && legal;
    rd_en     = func_active && is_read && legal;
    fault_nxt = func_active && (is_write || is_read) && !legal;
    word_idx  = bus.inAddress[AW+1:2];
  end

  // Write data is replicated across lanes so the lane enables alone pick the target bytes.
  always_comb begin
    lane_en   = '0;
    lane_data = '0;
    case (bus.size)
      2'b00: begin
        lane_en[bus.inAddress[1:0]] = 1'b1;
        lane_data = {4{bus.inWriteData[7:0]}};
      end
      2'b01: begin
        lane_en   = bus.inAddress[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{bus.inWriteData[15:0]}};
      end
      2'b10: begin
        lane_en   = '1;
        lane_data = bus.inWriteData;
      end
      default: ;
    endcase
  end

  // The clear sequence borrows the single write port while in CLEAR.
  always_comb begin
    if (state == CLEAR) begin
      mem_we    = '1;
      mem_idx   = clr_cnt;
      mem_wdata = '0;
    end else begin
      mem_we    = wr_en ? lane_en : '0;
      mem_idx   = word_idx;
      mem_wdata = lane_data;
    end
  end

  always_ff @(negedge clk) begin
    for (int unsigned k = 0; k < 4; k++) begin
      if (mem_we[k]) mem[mem_idx][8*k +: 8] <= mem_wdata[8*k +: 8];
    end
  end

  // ---------------- read formatting ----------------
  always_comb begin
    rd_word = mem[word_idx];
    case (bus.inAddress[1:0])
      2'b00:   rd_byte = rd_word[7:0];
      2'b01:   rd_byte = rd_word[15:8];
      2'b10:   rd_byte = rd_word[23:16];
      default: rd_byte = rd_word[31:24];
    endcase
    rd_half = bus.inAddress[1] ? rd_word[31:16] : rd_word[15:0];
    case (bus.size)
      2'b00:   rd_val = bus.load_unsigned ? {24'h0, rd_byte}
                                          : {{24{rd_byte[7]}}, rd_byte};
      2'b01:   rd_val = bus.load_unsigned ? {16'h0, rd_half}
                                          : {{16{rd_half[15]}}, rd_half};
      default: rd_val = rd_word;
    endcase
    dbg_in_range = (bus.Debug_read_mem[31:AW] == '0);
    dbg_word     = mem[bus.Debug_read_mem[AW-1:0]];
  end

  // ---------------- output registers ----------------
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      out_data_q <= '0;
      out_dbg_q  <= '0;
      fault_q    <= 1'b0;
    end else begin
      if (rd_en)        out_data_q <= rd_val;
      if (bus.Debug_on) out_dbg_q  <= dbg_in_range ? dbg_word : '0;
      fault_q <= fault_nxt;
    end
  end

  assign bus.outData     = out_data_q;
  assign bus.outMemDebug = out_dbg_q;
  assign bus.fault       = fault_q;
  assign bus.ready       = (state == IDLE);

endmodule

// File: tb/tb_dmem_bytelane.sv
// Self-checking bench for dmem_bytelane: vector table with a scoreboard queue,
// plus hand-written reset/clear and debug sequences.
module tb_dmem_bytelane;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dmem_bytelane_if bus ();

  dmem_bytelane #(.DEPTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [1:0]  rw;
    logic [1:0]  sz;
    logic        lu;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_data;
    logic        exp_fault;
  } vec_t;

  typedef struct packed {
    logic [31:0] data;
    logic        fault;
  } exp_t;

  vec_t vecs [23];
  exp_t sb [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic dbg, input logic [1:0] rw, input logic [1:0] sz,
                       input logic lu, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] dbg_idx);
    bus.Debug_on       = dbg;
    bus.read_write     = rw;
    bus.size           = sz;
    bus.load_unsigned  = lu;
    bus.inAddress      = addr;
    bus.inWriteData    = wd;
    bus.Debug_read_mem = dbg_idx;
  endtask

  task automatic edge_wait();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    drive(1'b0, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0);

    // rw, sz, lu, addr, wdata, expected outData, expected fault
    vecs[0]  = '{2'b01, 2'b10, 1'b0, 32'h10, 32'h8000_00F0, 32'h0000_0000, 1'b0};
    vecs[1]  = '{2'b10, 2'b00, 1'b0, 32'h10, 32'h0,         32'hFFFF_FFF0, 1'b0};
    vecs[2]  = '{2'b10, 2'b00, 1'b1, 32'h10, 32'h0,         32'h0000_00F0, 1'b0};
    vecs[3]  = '{2'b10, 2'b01, 1'b0, 32'h12, 32'h0,         32'hFFFF_8000, 1'b0};
    vecs[4]  = '{2'b10, 2'b01, 1'b1, 32'h12, 32'h0,         32'h0000_8000, 1'b0};
    vecs[5]  = '{2'b01, 2'b00, 1'b0, 32'h21, 32'hFFFF_FFAB, 32'h0000_8000, 1'b0};
    vecs[6]  = '{2'b10, 2'b10, 1'b0, 32'h20, 32'h0,         32'h0000_AB00, 1'b0};
    vecs[7]  = '{2'b01, 2'b10, 1'b0, 32'h06, 32'hDEAD_BEEF, 32'h0000_AB00, 1'b1};
    vecs[8]  = '{2'b00, 2'b10, 1'b0, 32'h06, 32'hDEAD_BEEF, 32'h0000_AB00, 1'b0};
    vecs[9]  = '{2'b10, 2'b01, 1'b0, 32'h03, 32'h0,         32'h0000_AB00, 1'b1};
    vecs[10] = '{2'b01, 2'b00, 1'b0, 32'h80, 32'h0000_0077, 32'h0000_AB00, 1'b1};
    vecs[11] = '{2'b10, 2'b11, 1'b0, 32'h10, 32'h0,         32'h0000_AB00, 1'b1};
    vecs[12] = '{2'b01, 2'b11, 1'b0, 32'h14, 32'h1234_5678, 32'h0000_AB00, 1'b1};
    vecs[13] = '{2'b10, 2'b10, 1'b0, 32'h10, 32'h0,         32'h8000_00F0, 1'b0};
    vecs[14] = '{2'b10, 2'b10, 1'b0, 32'h00, 32'h0,         32'h0000_0000, 1'b0};
    vecs[15] = '{2'b10, 2'b10, 1'b0, 32'h14, 32'h0,         32'h0000_0000, 1'b0};
    vecs[16] = '{2'b01, 2'b01, 1'b0, 32'h32, 32'h1234_BEEF, 32'h0000_0000, 1'b0};
    vecs[17] = '{2'b10, 2'b10, 1'b0, 32'h30, 32'h0,         32'hBEEF_0000, 1'b0};
    vecs[18] = '{2'b11, 2'b10, 1'b0, 32'h30, 32'h0,         32'hBEEF_0000, 1'b0};
    vecs[19] = '{2'b10, 2'b00, 1'b0, 32'h33, 32'h0,         32'hFFFF_FFBE, 1'b0};
    vecs[20] = '{2'b10, 2'b00, 1'b1, 32'h31, 32'h0,         32'h0000_0000, 1'b0};
    vecs[21] = '{2'b01, 2'b00, 1'b0, 32'h7F, 32'h0000_0055, 32'h0000_0000, 1'b0};
    vecs[22] = '{2'b10, 2'b01, 1'b0, 32'h7E, 32'h0,         32'h0000_5500, 1'b0};

    // Reset state
    repeat (2) edge_wait();
    chk("rst_outData", bus.outData, 32'h0);
    chk("rst_outMemDebug", bus.outMemDebug, 32'h0);
    chk("rst_ready", {31'h0, bus.ready}, 32'h0);
    chk("rst_fault", {31'h0, bus.fault}, 32'h0);

    // Clear sequence: ready rises after exactly 32 falling edges
    @(posedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      edge_wait();
      chk($sformatf("clear_ready_e%0d", i), {31'h0, bus.ready}, (i == 32) ? 32'h1 : 32'h0);
    end

    drive(1'b1, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0, 32'd5);
    edge_wait();
    chk("dbg_word5", bus.outMemDebug, 32'h0);
    drive(1'b0, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0, 32'd5);

    // Vector table through the scoreboard
    for (int i = 0; i < 23; i++) begin
      drive(1'b0, vecs[i].rw, vecs[i].sz, vecs[i].lu, vecs[i].addr, vecs[i].wd, 32'h0);
      sb.push_back('{vecs[i].exp_data, vecs[i].exp_fault});
      edge_wait();
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_empty vec%0d actual=empty expected=entry", i);
      end else begin
        e = sb.pop_front();
        chk($sformatf("vec%0d_data", i), bus.outData, e.data);
        chk($sformatf("vec%0d_fault", i), {31'h0, bus.fault}, {31'h0, e.fault});
      end
    end

    // Debug mode blocks functional accesses
    drive(1'b1, 2'b01, 2'b10, 1'b0, 32'h00, 32'hFFFF_FFFF, 32'd4);
    edge_wait();
    chk("dbg_w4", bus.outMemDebug, 32'h8000_00F0);
    chk("dbg_hold_data0", bus.outData, 32'h0000_5500);
    drive(1'b1, 2'b10, 2'b10, 1'b0, 32'h10, 32'h0, 32'd40);
    edge_wait();
    chk("dbg_oor40", bus.outMemDebug, 32'h0);
    chk("dbg_hold_data1", bus.outData, 32'h0000_5500);
    drive(1'b1, 2'b10, 2'b10, 1'b0, 32'h06, 32'h0, 32'd31);
    edge_wait();
    chk("dbg_w31", bus.outMemDebug, 32'h5500_0000);
    chk("dbg_no_fault", {31'h0, bus.fault}, 32'h0);
    drive(1'b0, 2'b00, 2'b10, 1'b0, 32'h00, 32'h0, 32'd4);
    edge_wait();
    chk("dbg_hold", bus.outMemDebug, 32'h5500_0000);
    drive(1'b0, 2'b10, 2'b10, 1'b0, 32'h00, 32'h0, 32'd4);
    edge_wait();
    chk("word0_unchanged", bus.outData, 32'h0);
    drive(1'b0, 2'b10, 2'b10, 1'b0, 32'h7C, 32'h0, 32'd4);
    edge_wait();
    chk("word31_before_rst", bus.outData, 32'h5500_0000);
    drive(1'b0, 2'b00, 2'b10, 1'b0, 32'h00, 32'h0, 32'd4);

    // Reset, then a second reset in the middle of the clear
    @(posedge clk);
    rst = 1'b1;
    #1;
    chk("rst2_outData", bus.outData, 32'h0);
    chk("rst2_outMemDebug", bus.outMemDebug, 32'h0);
    chk("rst2_ready", {31'h0, bus.ready}, 32'h0);
    @(posedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 10; i++) edge_wait();
    chk("midclear_ready", {31'h0, bus.ready}, 32'h0);
    @(posedge clk);
    rst = 1'b1;
    #1;
    chk("midclear_rst_ready", {31'h0, bus.ready}, 32'h0);
    @(posedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      case (i)
        20: drive(1'b0, 2'b01, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'h0);
        21: drive(1'b0, 2'b01, 2'b10, 1'b0, 32'h06, 32'hDEAD_BEEF, 32'h0);
        22: drive(1'b0, 2'b10, 2'b10, 1'b0, 32'h30, 32'h0, 32'h0);
        25: drive(1'b1, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0, 32'd4);
        default: drive(1'b0, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0);
      endcase
      edge_wait();
      chk($sformatf("reclear_ready_e%0d", i), {31'h0, bus.ready}, (i == 32) ? 32'h1 : 32'h0);
      if (i >= 20 && i <= 22) begin
        chk($sformatf("reclear_fault_e%0d", i), {31'h0, bus.fault}, 32'h0);
        chk($sformatf("reclear_data_e%0d", i), bus.outData, 32'h0);
      end
      if (i == 25) chk("reclear_dbg_w4", bus.outMemDebug, 32'h0);
    end
    drive(1'b0, 2'b10, 2'b10, 1'b0, 32'h30, 32'h0, 32'h0);
    edge_wait();
    chk("post_clear_w12", bus.outData, 32'h0);
    drive(1'b0, 2'b01, 2'b10, 1'b0, 32'h7C, 32'hCAFE_F00D, 32'h0);
    edge_wait();
    drive(1'b0, 2'b10, 2'b10, 1'b0, 32'h10, 32'h0, 32'h0);
    edge_wait();
    chk("clear_write_dropped", bus.outData, 32'h0);
    drive(1'b0, 2'b10, 2'b10, 1'b0, 32'h7C, 32'h0, 32'h0);
    edge_wait();
    chk("post_clear_write", bus.outData, 32'hCAFE_F00D);
    drive(1'b0, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
